multi_word_adder: RTL

MULTI_WORD_ADDER -- requirements
Module: multi_word_adder

---
 rtl/math_pkg.sv | 16 +
 rtl/lookahead_carry_adder.sv | 35 +++
 rtl/multi_word_adder.sv | 107 ++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared types and helpers for the multi-word adder: FSM state encoding and
// the slice-counter width calculation.
package math_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mwa_state_e;

    // Counter must be at least one bit wide even when only one slice exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lookahead_carry_adder.sv
// Combinational adder with carries formed from generate/propagate terms rather
// than a chained carry vector.
module lookahead_carry_adder #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             c_i,
    output logic [Width-1:0] s_o,
    output logic             c_o
);

    logic [Width-1:0] gen;
    logic [Width-1:0] prop;
    logic [Width-1:0] carry_in;
    logic             carry_acc;

    always_comb begin
        gen       = a_i & b_i;
        prop      = a_i ^ b_i;
        carry_in  = '0;
        carry_acc = 1'b0;
        // carry into bit i = g[i-1] | p[i-1]&g[i-2] | ... | p[i-1..0]&c_i
        for (int i = 0; i < int'(Width); i++) begin
            carry_acc = c_i;
            for (int j = 0; j < i; j++) begin
                carry_acc = gen[j] | (prop[j] & carry_acc);
            end
            carry_in[i] = carry_acc;
        end
        s_o = prop ^ carry_in;
        c_o = gen[Width-1] | (prop[Width-1] & carry_in[Width-1]);
    end

endmodule

// File: rtl/multi_word_adder.sv
// Sequential wide adder: operands are latched on accept and summed one
// D_WIDTH slice per cycle, with a registered result and valid/ready handshake.
module multi_word_adder
    import math_pkg::*;
#(
    parameter int unsigned D_WIDTH = 16,
    parameter int unsigned N_WORDS = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [D_WIDTH*N_WORDS-1:0] a_i,
    input  logic [D_WIDTH*N_WORDS-1:0] b_i,
    input  logic                       c_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [D_WIDTH*N_WORDS-1:0] s_o,
    output logic                       c_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i
);

    localparam int unsigned TotalW = D_WIDTH * N_WORDS;
    localparam int unsigned CntW   = cnt_width(N_WORDS);
    localparam logic [CntW-1:0] LastCnt = CntW'(N_WORDS - 1);

    mwa_state_e        state_q;
    logic [CntW-1:0]   cnt_q;
    logic              carry_q;
    logic [TotalW-1:0] a_q;
    logic [TotalW-1:0] b_q;
    logic [TotalW-1:0] s_q;
    logic              c_q;
    logic              out_valid_q;
    logic              ready_en_q;

    logic [D_WIDTH-1:0] slice_a;
    logic [D_WIDTH-1:0] slice_b;
    logic [D_WIDTH-1:0] slice_s;
    logic               slice_c;

    assign slice_a = a_q[int'(cnt_q)*D_WIDTH +: D_WIDTH];
    assign slice_b = b_q[int'(cnt_q)*D_WIDTH +: D_WIDTH];

    lookahead_carry_adder #(
        .Width (D_WIDTH)
    ) u_slice_adder (
        .a_i (slice_a),
        .b_i (slice_b),
        .c_i (carry_q),
        .s_o (slice_s),
        .c_o (slice_c)
    );

    // ready_en_q keeps in_ready_o low through reset and until the first edge after it.
    assign in_ready_o  = (state_q == StIdle) && ready_en_q;
    assign s_o         = s_q;
    assign c_o         = c_q;
    assign out_valid_o = out_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_o) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= c_i;
                        cnt_q   <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    s_q[int'(cnt_q)*D_WIDTH +: D_WIDTH] <= slice_s;
                    carry_q <= slice_c;
                    if (cnt_q == LastCnt) begin
                        c_q     <= slice_c;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // First DONE cycle raises valid; the handshake completes only once it is seen.
                    if (out_valid_q && out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
